// File: rtl/rf_pkg.sv
// Shared types and constants for the parametrised register file.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_READ = 2;

endpackage

// File: rtl/rf_read_port.sv
// One read port: entry mux with entry 0 hardwired to zero.
// Define RF_BYPASS_EN to forward same-transaction write data (write-first).
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] entries,
  input  logic [ADDR_W-1:0]                addr,
  input  logic                             write_enabled,
  input  logic [ADDR_W-1:0]                write_addr,
  input  logic [DATA_W-1:0]                write_data,
  output logic [DATA_W-1:0]                data
);

`ifdef RF_BYPASS_EN
  localparam logic BYPASS = ON;
`else
  localparam logic BYPASS = OFF;
`endif

  logic hit;

  assign hit = write_enabled && (write_addr == addr) && (addr != '0);

  always_comb begin
    data = '0;
    if (addr != '0) data = entries[addr];
    if (BYPASS && hit) data = write_data;
  end

endmodule

// File: rtl/rf_param.sv
// Parametrised register file with post-reset clear sweep and start/finish handshake.
// RF_BYPASS_EN selects write-first forwarding in the read ports.
module rf_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_READ = DEF_NUM_READ
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
  input  logic [ADDR_W-1:0]            write_addr,
  input  logic                         write_enabled,
  input  logic [DATA_W-1:0]            write_data,
  output logic                         busy,
  output logic                         finish,
  output logic [NUM_READ*DATA_W-1:0]   read_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  rf_state_t                     state, next_state;
  logic [ADDR_W-1:0]             clear_ptr;
  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [NUM_READ*DATA_W-1:0]    port_data;
  logic                          clear_en;
  logic                          accept;
  logic                          do_write;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clear_ptr == LAST) next_state = IDLE;
      IDLE:    next_state = IDLE;
      default: next_state = CLEAR;
    endcase
  end

  always_comb begin
    busy     = OFF;
    clear_en = OFF;
    accept   = OFF;
    case (state)
      CLEAR: begin
        busy     = ON;
        clear_en = ON;
      end
      IDLE:    accept = start;
      default: busy = ON;
    endcase
  end

  assign do_write = accept && write_enabled && (write_addr != '0);

  always_ff @(posedge clk) begin
    if (reset)         clear_ptr <= '0;
    else if (clear_en) clear_ptr <= clear_ptr + 1'b1;
  end

  // Storage has no reset of its own; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clear_en)      mem[clear_ptr]  <= '0;
      else if (do_write) mem[write_addr] <= write_data;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    rf_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_port (
      .entries      (mem),
      .addr         (read_addr[p*ADDR_W +: ADDR_W]),
      .write_enabled(write_enabled),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .data         (port_data[p*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      finish    <= OFF;
      read_data <= '0;
    end else if (accept) begin
      finish    <= ON;
      read_data <= port_data;
    end else begin
      finish    <= OFF;
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// Directed self-checking bench for rf_param at default parameters.
// Same-address expectations follow RF_BYPASS_EN when it is defined.
module tb_rf_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  read_addr = '0;
  logic [4:0]  write_addr = '0;
  logic        write_enabled = 1'b0;
  logic [31:0] write_data = '0;
  logic        busy;
  logic        finish;
  logic [63:0] read_data;

  int compared = 0;
  int mismatched = 0;

  rf_param dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .read_addr    (read_addr),
    .write_addr   (write_addr),
    .write_enabled(write_enabled),
    .write_data   (write_data),
    .busy         (busy),
    .finish       (finish),
    .read_data    (read_data)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [4:0] a0, input logic [4:0] a1, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd);
    read_addr     = {a1, a0};
    write_enabled = we;
    write_addr    = wa;
    write_data    = wd;
    start         = 1'b1;
    cycle();
    start         = 1'b0;
    write_enabled = 1'b0;
  endtask

  // Counts samples with busy high, starting from the sample after the last reset edge.
  task automatic count_sweep(output int n);
    n = 0;
    for (int k = 0; k < 100 && busy; k++) begin
      n++;
      cycle();
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    cycle();
    cycle();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_busy got %b want 1", busy);
    end
    compared++;
    if (finish !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_finish got %b want 0", finish);
    end
    compared++;
    if (read_data !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_read_data got %h want 0", read_data);
    end
    reset = 1'b0;
    count_sweep(n);
    compared++;
    if (n !== 32) begin
      mismatched++;
      $display("[TB] FAIL sweep_length got %0d want 32", n);
    end
    for (int i = 1; i < 32; i++) begin
      txn(5'(i), 5'(i), 1'b0, 5'd0, 32'h0);
      compared++;
      if (finish !== 1'b1 || read_data !== 64'h0) begin
        mismatched++;
        $display("[TB] FAIL cleared_entry_%0d got finish=%b data=%h want finish=1 data=0",
                 i, finish, read_data);
      end
    end
  endtask

  task automatic test_write_read();
    txn(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    txn(5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
    compared++;
    if (read_data !== {32'h0, 32'hDEADBEEF}) begin
      mismatched++;
      $display("[TB] FAIL write_read_5 got %h want 00000000deadbeef", read_data);
    end
    compared++;
    if (finish !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL finish_pulse_high got %b want 1", finish);
    end
    cycle();
    compared++;
    if (finish !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL finish_pulse_low got %b want 0", finish);
    end
    compared++;
    if (read_data !== {32'h0, 32'hDEADBEEF}) begin
      mismatched++;
      $display("[TB] FAIL read_data_hold got %h want 00000000deadbeef", read_data);
    end
  endtask

  task automatic test_zero_entry();
    txn(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678);
    compared++;
    if (read_data !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL zero_same_txn got %h want 0", read_data);
    end
    txn(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    compared++;
    if (read_data !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL zero_entry got %h want 0", read_data);
    end
  endtask

  task automatic test_same_addr();
    logic [31:0] want;
`ifdef RF_BYPASS_EN
    want = 32'h2;
`else
    want = 32'h1;
`endif
    txn(5'd0, 5'd0, 1'b1, 5'd7, 32'h1);
    txn(5'd7, 5'd7, 1'b1, 5'd7, 32'h2);
    compared++;
    if (read_data !== {want, want}) begin
      mismatched++;
      $display("[TB] FAIL same_addr_rw got %h want %h", read_data, {want, want});
    end
    txn(5'd7, 5'd0, 1'b0, 5'd0, 32'h0);
    compared++;
    if (read_data !== {32'h0, 32'h2}) begin
      mismatched++;
      $display("[TB] FAIL same_addr_after got %h want 0000000000000002", read_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a0 [4];
    logic [4:0]  a1 [4];
    logic [63:0] want [4];
    txn(5'd0, 5'd0, 1'b1, 5'd10, 32'hA0A0000A);
    txn(5'd0, 5'd0, 1'b1, 5'd11, 32'hB0B0000B);
    txn(5'd0, 5'd0, 1'b1, 5'd12, 32'hC0C0000C);
    txn(5'd0, 5'd0, 1'b1, 5'd13, 32'hD0D0000D);
    a0[0] = 5'd10; a1[0] = 5'd11; want[0] = {32'hB0B0000B, 32'hA0A0000A};
    a0[1] = 5'd20; a1[1] = 5'd12; want[1] = {32'hC0C0000C, 32'h55AA0014};
    a0[2] = 5'd13; a1[2] = 5'd10; want[2] = {32'hA0A0000A, 32'hD0D0000D};
    a0[3] = 5'd0;  a1[3] = 5'd5;  want[3] = {32'hDEADBEEF, 32'h0};
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      read_addr     = {a1[k], a0[k]};
      write_enabled = (k == 0);
      write_addr    = 5'd20;
      write_data    = 32'h55AA0014;
      cycle();
      compared++;
      if (finish !== 1'b1 || read_data !== want[k]) begin
        mismatched++;
        $display("[TB] FAIL b2b_txn_%0d got finish=%b data=%h want finish=1 data=%h",
                 k, finish, read_data, want[k]);
      end
    end
    start = 1'b0;
    write_enabled = 1'b0;
    cycle();
    compared++;
    if (finish !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_finish_drop got %b want 0", finish);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    txn(5'd0, 5'd0, 1'b1, 5'd9, 32'hCAFE0009);
    read_addr = {5'd9, 5'd9};
    start = 1'b1;
    reset = 1'b1;
    cycle();
    start = 1'b0;
    reset = 1'b0;
    compared++;
    if (finish !== 1'b0 || busy !== 1'b1 || read_data !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_txn got finish=%b busy=%b data=%h want 0 1 0",
               finish, busy, read_data);
    end
    start = 1'b1;
    write_enabled = 1'b1;
    write_addr = 5'd3;
    write_data = 32'h33333333;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (finish !== 1'b0) n++;
    end
    start = 1'b0;
    write_enabled = 1'b0;
    compared++;
    if (n !== 0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL start_during_sweep got finish_highs=%0d busy=%b want 0 1", n, busy);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    compared++;
    if (busy !== 1'b1 || finish !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_sweep got busy=%b finish=%b want 1 0", busy, finish);
    end
    count_sweep(n);
    compared++;
    if (n !== 32) begin
      mismatched++;
      $display("[TB] FAIL restart_sweep_length got %0d want 32", n);
    end
    txn(5'd9, 5'd3, 1'b0, 5'd0, 32'h0);
    compared++;
    if (finish !== 1'b1 || read_data !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL entry_cleared_after_reset got finish=%b data=%h want 1 0",
               finish, read_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_entry();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
